// File: rtl/tank_pkg.sv
// Shared state type, keycodes and per-player defaults for the tank turn sequencer.
package tank_pkg;

   typedef enum logic [2:0] {
      AIM,
      LAUNCH,
      ARM,
      FLIGHT,
      SETTLE,
      SWITCH
   } turn_state_t;

   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

   localparam logic [3:0] ANGLE_MAX  = 4'd8;
   localparam logic [2:0] POWER_MAX  = 3'd7;
   localparam logic [3:0] ANGLE_DEF0 = 4'd6;
   localparam logic [3:0] ANGLE_DEF1 = 4'd2;
   localparam logic [2:0] POWER_DEF  = 3'd3;

   // Frame counters stick at all-ones instead of wrapping.
   function automatic logic [9:0] sat_inc10(input logic [9:0] v);
      return (v == '1) ? v : v + 10'd1;
   endfunction

endpackage

// File: rtl/key_repeat.sv
// Keycode registration, new-press detection and held-key auto-repeat.
// act_o is a one-clk strobe on the frame_tick where the registered key should act.
module key_repeat
   import tank_pkg::*;
#(
   parameter int unsigned REPEAT_FRAMES = 8
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       frame_tick_i,
   input  logic [7:0] keycode_i,
   input  logic       load_prev_i,
   output logic       act_o,
   output logic       new_o,
   output logic [7:0] code_o
);

   localparam logic [9:0] REPEAT_LIM = 10'(REPEAT_FRAMES);

   logic [7:0] key_q;
   logic [7:0] last_q;
   logic [9:0] cnt_q, cnt_d;
   logic [9:0] cnt_inc;
   logic       held;
   logic       fire_repeat;

   assign held        = (key_q != '0) && (key_q == last_q);
   assign new_o       = (key_q != '0) && (key_q != last_q);
   assign cnt_inc     = sat_inc10(cnt_q);
   assign fire_repeat = held && (cnt_inc >= REPEAT_LIM);
   assign act_o       = frame_tick_i && (new_o || fire_repeat);
   assign code_o      = key_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_prev_i || (key_q == '0)) begin
         cnt_d = '0;
      end else if (frame_tick_i) begin
         cnt_d = (!held || fire_repeat) ? '0 : cnt_inc;
      end
   end

   // last_q follows the key seen at each frame_tick; loading it on a turn
   // switch makes a key held across the switch look like a repeat, not a press.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         key_q  <= '0;
         last_q <= '0;
         cnt_q  <= '0;
      end else begin
         key_q <= keycode_i;
         cnt_q <= cnt_d;
         if (load_prev_i || frame_tick_i) begin
            last_q <= key_q;
         end
      end
   end

endmodule

// File: rtl/turn_controller.sv
// Turn sequencer: keyboard aim, launch handshake, flight/settle tracking, player swap.
// Build option AIM_TIMER_EN adds an aim time limit with auto-fire and aim_time_left.
module turn_controller
   import tank_pkg::*;
#(
   parameter int unsigned REPEAT_FRAMES  = 8,
   parameter int unsigned SETTLE_FRAMES  = 4,
   parameter int unsigned FLIGHT_TIMEOUT = 600
`ifdef AIM_TIMER_EN
   ,
   parameter int unsigned TURN_FRAMES    = 900
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic [7:0] keycode,
   input  logic       exploded,
   input  logic [9:0] tank0_x,
   input  logic [9:0] tank0_y,
   input  logic [9:0] tank1_x,
   input  logic [9:0] tank1_y,
   output logic       launch,
   output logic [9:0] launchX,
   output logic [9:0] launchY,
   output logic [3:0] angle,
   output logic [2:0] power,
   output logic       player,
   output logic       busy
`ifdef AIM_TIMER_EN
   ,
   output logic [9:0] aim_time_left
`endif
);

   localparam logic [9:0] SETTLE_LIM = 10'(SETTLE_FRAMES);
   localparam logic [9:0] FLIGHT_LIM = 10'(FLIGHT_TIMEOUT);
   localparam logic [9:0] ARM_LIM    = 10'd2;

   turn_state_t state_q;
   logic        player_q;
   logic        launch_q;
   logic        busy_q;
   logic [3:0]  angle_q [2];
   logic [2:0]  power_q [2];
   logic [9:0]  cnt_q;
   logic [9:0]  cnt_inc;
   logic        key_act;
   logic        key_new;
   logic [7:0]  key_code;
   logic        in_switch;
   logic        aim_fire;
   logic        space_fire;

   assign in_switch = (state_q == SWITCH);

   key_repeat #(
      .REPEAT_FRAMES(REPEAT_FRAMES)
   ) u_keys (
      .clk_i       (clk),
      .reset_i     (reset),
      .frame_tick_i(frame_tick),
      .keycode_i   (keycode),
      .load_prev_i (in_switch),
      .act_o       (key_act),
      .new_o       (key_new),
      .code_o      (key_code)
   );

   assign cnt_inc    = sat_inc10(cnt_q);
   assign space_fire = key_act && key_new && (key_code == KEY_SPACE);

   assign launch  = launch_q;
   assign busy    = busy_q;
   assign player  = player_q;
   assign angle   = angle_q[player_q];
   assign power   = power_q[player_q];
   assign launchX = player_q ? tank1_x : tank0_x;
   assign launchY = player_q ? tank1_y : tank0_y;

`ifdef AIM_TIMER_EN
   localparam logic [9:0] TURN_LIM = 10'(TURN_FRAMES);
   assign aim_fire      = frame_tick && (cnt_inc >= TURN_LIM);
   assign aim_time_left = (state_q == AIM) ? (TURN_LIM - cnt_q) : '0;
`else
   assign aim_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= AIM;
         player_q   <= 1'b0;
         launch_q   <= 1'b0;
         busy_q     <= 1'b0;
         cnt_q      <= '0;
         angle_q[0] <= ANGLE_DEF0;
         angle_q[1] <= ANGLE_DEF1;
         power_q[0] <= POWER_DEF;
         power_q[1] <= POWER_DEF;
      end else begin
         case (state_q)
            AIM: begin
               if (frame_tick) cnt_q <= cnt_inc;
               if (space_fire || aim_fire) begin
                  state_q  <= LAUNCH;
                  launch_q <= 1'b1;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
               end else if (key_act) begin
                  case (key_code)
                     KEY_A: if (angle_q[player_q] != '0)
                               angle_q[player_q] <= angle_q[player_q] - 4'd1;
                     KEY_D: if (angle_q[player_q] < ANGLE_MAX)
                               angle_q[player_q] <= angle_q[player_q] + 4'd1;
                     KEY_S: if (power_q[player_q] != '0)
                               power_q[player_q] <= power_q[player_q] - 3'd1;
                     KEY_W: if (power_q[player_q] < POWER_MAX)
                               power_q[player_q] <= power_q[player_q] + 3'd1;
                     default: ;
                  endcase
               end
            end
            // launch spans exactly one frame so the projectile block sees one edge
            LAUNCH: begin
               if (frame_tick) begin
                  launch_q <= 1'b0;
                  state_q  <= ARM;
                  cnt_q    <= '0;
               end
            end
            ARM: begin
               if (!exploded) begin
                  state_q <= FLIGHT;
                  cnt_q   <= '0;
               end else if (frame_tick) begin
                  if (cnt_inc >= ARM_LIM) begin
                     state_q <= SETTLE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
            end
            FLIGHT: begin
               if (exploded) begin
                  state_q <= SETTLE;
                  cnt_q   <= '0;
               end else if (frame_tick) begin
                  if (cnt_inc >= FLIGHT_LIM) begin
                     state_q <= SETTLE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
            end
            SETTLE: begin
               if (frame_tick) begin
                  if (cnt_inc >= SETTLE_LIM) begin
                     state_q <= SWITCH;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
            end
            SWITCH: begin
               player_q <= ~player_q;
               busy_q   <= 1'b0;
               cnt_q    <= '0;
               state_q  <= AIM;
            end
            default: state_q <= AIM;
         endcase
      end
   end

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller with a frame-level reference model.
`timescale 1ns/1ps
module tb_turn_controller;

   localparam int FP = 8;   // clocks per video frame
   localparam int R  = 8;   // REPEAT_FRAMES

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic       exploded = 1'b1;
   logic [9:0] tank0_x = 10'd100;
   logic [9:0] tank0_y = 10'd300;
   logic [9:0] tank1_x = 10'd700;
   logic [9:0] tank1_y = 10'd250;
   logic       launch;
   logic [9:0] launchX, launchY;
   logic [3:0] angle;
   logic [2:0] power;
   logic       player;
   logic       busy;
`ifdef AIM_TIMER_EN
   logic [9:0] aim_time_left;
`endif

   int tests = 0;
   int fails = 0;
   int tick_count = 0;
   int exp_angle [2];
   int exp_power [2];

   turn_controller #(
      .REPEAT_FRAMES(8),
      .SETTLE_FRAMES(4),
      .FLIGHT_TIMEOUT(600)
`ifdef AIM_TIMER_EN
      ,
      .TURN_FRAMES(900)
`endif
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .keycode(keycode),
      .exploded(exploded), .tank0_x(tank0_x), .tank0_y(tank0_y),
      .tank1_x(tank1_x), .tank1_y(tank1_y), .launch(launch),
      .launchX(launchX), .launchY(launchY), .angle(angle), .power(power),
      .player(player), .busy(busy)
`ifdef AIM_TIMER_EN
      ,
      .aim_time_left(aim_time_left)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (FP - 1) @(negedge clk);
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
      end
   end

   always @(posedge clk) if (frame_tick) tick_count <= tick_count + 1;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: sim time exceeded, required completion before limit");
      $fatal(1);
   end

   // Model helpers: a key held for n frames acts 1 + (n-1)/R times.
   function automatic int acts_for(input int n);
      return (n <= 0) ? 0 : 1 + (n - 1) / R;
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   task automatic apply_key(input int p, input logic [7:0] code, input int n);
      int a;
      a = acts_for(n);
      case (code)
         8'h04: exp_angle[p] = clamp(exp_angle[p] - a, 0, 8);
         8'h07: exp_angle[p] = clamp(exp_angle[p] + a, 0, 8);
         8'h1A: exp_power[p] = clamp(exp_power[p] + a, 0, 7);
         8'h16: exp_power[p] = clamp(exp_power[p] - a, 0, 7);
         default: ;
      endcase
   endtask

   task automatic tick();
      do @(posedge clk); while (frame_tick !== 1'b1);
      #1;
   endtask

   // Hold a key for exactly n frame_ticks as seen by the DUT, then release for two.
   task automatic hold(input logic [7:0] code, input int n);
      @(negedge clk) keycode = code;
      @(posedge clk);
      repeat (n) tick();
      @(negedge clk) keycode = 8'h00;
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (angle !== 4'd6) begin fails++; $display("FAIL reset_angle: got %0d expected 6", angle); end
      tests++; if (power !== 3'd3) begin fails++; $display("FAIL reset_power: got %0d expected 3", power); end
      tests++; if (player !== 1'b0) begin fails++; $display("FAIL reset_player: got %0b expected 0", player); end
      tests++; if (launch !== 1'b0) begin fails++; $display("FAIL reset_launch: got %0b expected 0", launch); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      @(negedge clk) reset = 1'b0;
      exp_angle[0] = 6; exp_angle[1] = 2; exp_power[0] = 3; exp_power[1] = 3;
   endtask

   task automatic test_hold_repeat();
      int e;
      @(negedge clk) keycode = 8'h07;
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         tick();
         e = clamp(6 + acts_for(k), 0, 8);
         tests++;
         if (angle !== 4'(e)) begin
            fails++; $display("FAIL hold_d_frame%0d: angle got %0d expected %0d", k, angle, e);
         end
      end
      @(negedge clk) keycode = 8'h00;
      tick();
      tick();
      exp_angle[0] = e;
   endtask

   task automatic test_power_sat();
      for (int i = 0; i < 5; i++) begin
         hold(8'h16, 1);
         apply_key(0, 8'h16, 1);
         tests++;
         if (power !== 3'(exp_power[0])) begin
            fails++; $display("FAIL power_down%0d: got %0d expected %0d", i, power, exp_power[0]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         hold(8'h1A, 1);
         apply_key(0, 8'h1A, 1);
         tests++;
         if (power !== 3'(exp_power[0])) begin
            fails++; $display("FAIL power_up%0d: got %0d expected %0d", i, power, exp_power[0]);
         end
      end
   endtask

   task automatic test_random_adjust();
      logic [7:0] codes [5];
      logic [7:0] c;
      int n;
      codes[0] = 8'h04; codes[1] = 8'h07; codes[2] = 8'h1A; codes[3] = 8'h16; codes[4] = 8'h10;
      for (int i = 0; i < 12; i++) begin
         c = codes[$urandom_range(0, 4)];
         n = $urandom_range(1, 20);
         hold(c, n);
         apply_key(0, c, n);
         tests++;
         if (angle !== 4'(exp_angle[0]) || power !== 3'(exp_power[0])) begin
            fails++;
            $display("FAIL rand_adjust%0d key %h x%0d: angle/power got %0d/%0d expected %0d/%0d",
                     i, c, n, angle, power, exp_angle[0], exp_power[0]);
         end
      end
   endtask

   task automatic test_launch_flight();
      int n0;
      int width;
      tank1_x = 10'($urandom_range(0, 1023));
      tank1_y = 10'($urandom_range(0, 1023));
      exploded = 1'b1;
      @(negedge clk) keycode = 8'h2C;
      @(posedge clk);
      tick();
      n0 = tick_count;
      tests++; if (launch !== 1'b1) begin fails++; $display("FAIL launch_rise: got %0b expected 1", launch); end
      tests++; if (launchX !== 10'd100 || launchY !== 10'd300) begin
         fails++; $display("FAIL launch_origin: got %0d,%0d expected 100,300", launchX, launchY); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL launch_busy: got %0b expected 1", busy); end
      width = 1;
      for (int i = 0; i < 4 * FP; i++) begin
         @(posedge clk); #1;
         if (launch === 1'b1) width++; else break;
      end
      tests++; if (width != FP) begin fails++; $display("FAIL launch_width: got %0d clks expected %0d", width, FP); end
      @(negedge clk) begin keycode = 8'h00; exploded = 1'b0; end
      hold(8'h07, 10);
      hold(8'h16, 10);
      tests++;
      if (angle !== 4'(exp_angle[0]) || power !== 3'(exp_power[0]) || busy !== 1'b1) begin
         fails++; $display("FAIL keys_in_flight: angle/power/busy got %0d/%0d/%0b expected %0d/%0d/1",
                           angle, power, busy, exp_angle[0], exp_power[0]);
      end
      while (tick_count < n0 + 40) tick();
      @(negedge clk) exploded = 1'b1;
      repeat (3) tick();
      tests++; if (player !== 1'b0 || busy !== 1'b1) begin
         fails++; $display("FAIL settle_early: player/busy got %0b/%0b expected 0/1", player, busy); end
      tick();
      repeat (3) @(posedge clk);
      #1;
      tests++; if (player !== 1'b1 || busy !== 1'b0) begin
         fails++; $display("FAIL switch_p1: player/busy got %0b/%0b expected 1/0", player, busy); end
      tests++; if (angle !== 4'(exp_angle[1]) || power !== 3'(exp_power[1])) begin
         fails++; $display("FAIL switch_p1_settings: angle/power got %0d/%0d expected %0d/%0d",
                           angle, power, exp_angle[1], exp_power[1]); end
      tests++; if (launchX !== tank1_x || launchY !== tank1_y) begin
         fails++; $display("FAIL switch_p1_origin: got %0d,%0d expected %0d,%0d",
                           launchX, launchY, tank1_x, tank1_y); end
   endtask

   task automatic test_timeout_held_space();
      int n0;
      @(negedge clk) keycode = 8'h2C;
      @(posedge clk);
      tick();
      n0 = tick_count;
      tests++; if (launch !== 1'b1 || launchX !== tank1_x) begin
         fails++; $display("FAIL p1_launch: launch/x got %0b/%0d expected 1/%0d", launch, launchX, tank1_x); end
      @(negedge clk) keycode = 8'h00;
      tick();
      @(negedge clk) exploded = 1'b0;
      while (tick_count < n0 + 590) tick();
      @(negedge clk) keycode = 8'h2C;
      while (tick_count < n0 + 604) tick();
      tests++; if (player !== 1'b1 || busy !== 1'b1) begin
         fails++; $display("FAIL timeout_early: player/busy got %0b/%0b expected 1/1", player, busy); end
      tick();
      repeat (3) @(posedge clk);
      #1;
      tests++; if (player !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL timeout_switch: player/busy got %0b/%0b expected 0/0", player, busy); end
      for (int k = 0; k < 20; k++) begin
         tick();
         tests++;
         if (launch !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL held_space%0d: launch/busy got %0b/%0b expected 0/0", k, launch, busy);
         end
      end
      @(negedge clk) keycode = 8'h00;
      tick();
      tick();
      @(negedge clk) keycode = 8'h2C;
      @(posedge clk);
      tick();
      tests++; if (launch !== 1'b1 || launchX !== 10'd100) begin
         fails++; $display("FAIL repress_launch: launch/x got %0b/%0d expected 1/100", launch, launchX); end
      @(negedge clk) keycode = 8'h00;
   endtask

   task automatic test_reset_mid_flight();
      repeat (5) tick();
      tests++; if (busy !== 1'b1 || launch !== 1'b0) begin
         fails++; $display("FAIL in_flight: busy/launch got %0b/%0b expected 1/0", busy, launch); end
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      tests++; if (launch !== 1'b0 || player !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL mid_reset: launch/player/busy got %0b/%0b/%0b expected 0/0/0",
                           launch, player, busy); end
      tests++; if (angle !== 4'd6 || power !== 3'd3) begin
         fails++; $display("FAIL mid_reset_settings: angle/power got %0d/%0d expected 6/3", angle, power); end
      @(negedge clk) reset = 1'b0;
   endtask

`ifdef AIM_TIMER_EN
   task automatic test_aim_timer();
      int r0;
      r0 = tick_count;
      tests++; if (aim_time_left !== 10'd900) begin
         fails++; $display("FAIL timer_start: got %0d expected 900", aim_time_left); end
      while (tick_count < r0 + 899) tick();
      tests++; if (launch !== 1'b0 || aim_time_left !== 10'd1) begin
         fails++; $display("FAIL timer_899: launch/left got %0b/%0d expected 0/1", launch, aim_time_left); end
      tick();
      tests++; if (launch !== 1'b1 || aim_time_left !== 10'd0) begin
         fails++; $display("FAIL timer_fire: launch/left got %0b/%0d expected 1/0", launch, aim_time_left); end
   endtask
`endif

   initial begin
      test_reset();
      test_hold_repeat();
      test_power_sat();
      test_random_adjust();
      test_launch_flight();
      test_timeout_held_space();
      test_reset_mid_flight();
`ifdef AIM_TIMER_EN
      test_aim_timer();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
